// File: rtl/frame_fifo_writer.sv
// Pixel-domain producer for the PC frame pipe: resets the transfer FIFO on request,
// captures one frame from SOF, and writes exactly FRAME_BYTES words (zero-padding short frames).
module frame_fifo_writer #(
    parameter int FRAME_BYTES = 307200,
    parameter int BLOCK_BYTES = 1024,
    parameter int RST_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        USB_ready,
    input  logic        pix_sof,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic        pix_eof,
    input  logic        FIFO_full,
    output logic        FIFO_write_reset,
    output logic        FIFO_read_reset,
    output logic        FIFO_wr_enable,
    output logic [31:0] FIFO_data_in,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] frame_count
);
    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BYTES);
    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);

    // A frame must always end on a whole PC pipe block.
    if (FRAME_BYTES % BLOCK_BYTES != 0) begin : g_bad_geometry
        $error("frame_fifo_writer: FRAME_BYTES must be a multiple of BLOCK_BYTES");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIFO_RST,
        ST_WAIT_SOF,
        ST_STREAM,
        ST_PAD,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           usb_ready_q, usb_prev_q;
    logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
    logic           wr_en_q, wr_en_d;
    logic [31:0]    data_q, data_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    frame_count_q, frame_count_d;
    logic [CW-1:0]  byte_cnt_inc;
    logic           req_edge;
    logic           take_pixel;

    assign req_edge     = usb_ready_q & ~usb_prev_q;
    assign byte_cnt_inc = byte_cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        rst_cnt_d     = rst_cnt_q;
        wr_en_d       = 1'b0;
        data_d        = data_q;
        overflow_d    = overflow_q;
        frame_count_d = frame_count_q;
        take_pixel    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_edge) begin
                    overflow_d = 1'b0;
                    rst_cnt_d  = '0;
                    state_d    = ST_FIFO_RST;
                end
            end
            ST_FIFO_RST: begin
                rst_cnt_d = rst_cnt_q + 1'b1;
                if (rst_cnt_q == RST_LAST) begin
                    byte_cnt_d = '0;
                    state_d    = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                take_pixel = pix_valid & pix_sof;
            end
            ST_STREAM: begin
                take_pixel = pix_valid;
                if (!pix_valid && pix_eof) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                // Padding waits out a full FIFO rather than dropping words.
                if (!FIFO_full) begin
                    wr_en_d    = 1'b1;
                    data_d     = '0;
                    byte_cnt_d = byte_cnt_inc;
                    if (byte_cnt_inc == FRAME_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                frame_count_d = frame_count_q + 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropped pixels still advance the counter so frame geometry is preserved.
        if (take_pixel) begin
            byte_cnt_d = byte_cnt_inc;
            if (FIFO_full) begin
                overflow_d = 1'b1;
            end else begin
                wr_en_d = 1'b1;
                data_d  = {22'd0, pix_data, 2'b00};
            end
            if (byte_cnt_inc == FRAME_LAST) begin
                state_d = ST_DONE;
            end else if (pix_eof) begin
                state_d = ST_PAD;
            end else begin
                state_d = ST_STREAM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            usb_ready_q   <= 1'b0;
            usb_prev_q    <= 1'b0;
            byte_cnt_q    <= '0;
            rst_cnt_q     <= '0;
            wr_en_q       <= 1'b0;
            data_q        <= '0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            usb_ready_q   <= USB_ready;
            usb_prev_q    <= usb_ready_q;
            byte_cnt_q    <= byte_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            wr_en_q       <= wr_en_d;
            data_q        <= data_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign FIFO_write_reset = (state_q == ST_FIFO_RST);
    assign FIFO_read_reset  = (state_q == ST_FIFO_RST);
    assign FIFO_wr_enable   = wr_en_q;
    assign FIFO_data_in     = data_q;
    assign overflow         = overflow_q;
    assign frame_count      = frame_count_q;

endmodule
